// File: rtl/bram16_rr_arbiter.sv
// Round-robin arbiter sharing the 256x16 port B of a dual-port block RAM between two
// requesters, with registered port-B drive, a tagged read-return pipe and a zero-fill sequencer.
module bram16_rr_arbiter #(
  parameter int                 ADDR_W         = 8,
  parameter int                 DATA_W         = 16,
  parameter bit                 CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE    = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA,
  input  logic              CLR_START,
  output logic              BUSY,
  output logic              ENB,
  output logic              WEB,
  output logic [ADDR_W-1:0] ADDRB,
  output logic [DATA_W-1:0] DIB,
  input  logic [DATA_W-1:0] DOB
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   cnt_nxt_s;
  logic                ptr_r;
  logic                gnt0_s;
  logic                gnt1_s;
  logic                xfer_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                tag_valid_r;
  logic                tag_id_r;

  // Fill FSM next state and arbitration; a fill start suppresses any grant that cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (CLR_START) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = '0;
        end else begin
          // ptr_r = 0 favours requester 0 under contention
          if (REQ0 && (!REQ1 || !ptr_r)) begin
            gnt0_s = 1'b1;
          end else if (REQ1) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Command selected for the port-B register stage.
  always_comb begin
    xfer_s      = gnt0_s | gnt1_s;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (gnt1_s) begin
      sel_we_s    = WE1;
      sel_addr_s  = ADDR1;
      sel_wdata_s = WDATA1;
    end else begin
      sel_we_s    = WE0;
      sel_addr_s  = ADDR0;
      sel_wdata_s = WDATA0;
    end
  end

  // Fill FSM state and counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Round-robin pointer moves to the requester that lost each transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_r <= 1'b0;
    end else if (xfer_s) begin
      ptr_r <= gnt0_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Registered port-B drive; address and data hold when the port is idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ENB   <= 1'b0;
      WEB   <= 1'b0;
      ADDRB <= '0;
      DIB   <= '0;
    end else if (state_r == ST_CLEAR) begin
      ENB   <= 1'b1;
      WEB   <= 1'b1;
      ADDRB <= cnt_r;
      DIB   <= CLEAR_VALUE;
    end else if (xfer_s) begin
      ENB   <= 1'b1;
      WEB   <= sel_we_s;
      ADDRB <= sel_addr_s;
      DIB   <= sel_wdata_s;
    end else begin
      ENB   <= 1'b0;
      WEB   <= 1'b0;
    end
  end

  // Two-stage read tag: command on the pins, then RAM output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_valid_r <= 1'b0;
      tag_id_r    <= 1'b0;
      RVALID0     <= 1'b0;
      RVALID1     <= 1'b0;
    end else begin
      tag_valid_r <= xfer_s & ~sel_we_s;
      tag_id_r    <= gnt1_s;
      RVALID0     <= tag_valid_r & ~tag_id_r;
      RVALID1     <= tag_valid_r & tag_id_r;
    end
  end

  assign GNT0  = gnt0_s;
  assign GNT1  = gnt1_s;
  assign BUSY  = (state_r == ST_CLEAR);
  assign RDATA = DOB;

endmodule

// File: tb/tb_bram16_rr_arbiter.sv
// Directed bench: a write-first RAM model behind port B, a vector table for arbitration and
// latency, and hand sequences for fill, busy-ignore and reset aborts.
module tb_bram16_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0, CLR_START = 1'b0;
  logic [7:0]  ADDR0 = 8'h00, ADDR1 = 8'h00;
  logic [15:0] WDATA0 = 16'h0000, WDATA1 = 16'h0000;
  logic        GNT0, GNT1, RVALID0, RVALID1, BUSY, ENB, WEB;
  logic [15:0] RDATA, DIB, DOB;
  logic [7:0]  ADDRB;

  logic        c_gnt0, c_gnt1, c_rv0, c_rv1, c_busy, c_enb, c_web;
  logic [15:0] c_rdata, c_dib;
  logic [7:0]  c_addrb;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bram16_rr_arbiter #(.CLEAR_ON_RESET(1'b0)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA(RDATA),
    .CLR_START(CLR_START), .BUSY(BUSY), .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB),
    .DIB(DIB), .DOB(DOB)
  );

  bram16_rr_arbiter #(.CLEAR_ON_RESET(1'b1)) dut_c (
    .CLK(CLK), .RST(RST), .REQ0(1'b0), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
    .ADDR0(8'h00), .ADDR1(8'h00), .WDATA0(16'h0000), .WDATA1(16'h0000),
    .GNT0(c_gnt0), .GNT1(c_gnt1), .RVALID0(c_rv0), .RVALID1(c_rv1), .RDATA(c_rdata),
    .CLR_START(1'b0), .BUSY(c_busy), .ENB(c_enb), .WEB(c_web), .ADDRB(c_addrb),
    .DIB(c_dib), .DOB(16'h0000)
  );

  // Write-first RAM with registered output; preloaded on the first clock (held in reset).
  logic [15:0] mem [256];
  logic        ram_init = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
      mem[8'h05] <= 16'hA5A5;
      mem[8'h20] <= 16'h2020;
      mem[8'h21] <= 16'h2121;
      DOB        <= 16'h0000;
      ram_init   <= 1'b1;
    end else if (ENB) begin
      if (WEB) begin
        mem[ADDRB] <= DIB;
        DOB        <= DIB;
      end else begin
        DOB <= mem[ADDRB];
      end
    end
  end

  typedef struct {
    logic        req0, we0;
    logic [7:0]  addr0;
    logic [15:0] wdata0;
    logic        req1, we1;
    logic [7:0]  addr1;
    logic [15:0] wdata1;
    logic        gnt0, gnt1, enb, web;
    logic [7:0]  addrb;
    logic [15:0] dib;
    logic        rv0, rv1;
    logic [15:0] rdata;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0; CLR_START = 1'b0;
    ADDR0 = 8'h00; ADDR1 = 8'h00; WDATA0 = 16'h0000; WDATA1 = 16'h0000;
  endtask

  task automatic chk_bus(input string nm, input logic enb, input logic web, input logic [7:0] addrb);
    chk({nm, " ENB"}, 32'(ENB), 32'(enb));
    chk({nm, " WEB"}, 32'(WEB), 32'(web));
    chk({nm, " ADDRB"}, 32'(ADDRB), 32'(addrb));
  endtask

  initial begin
    // inputs:  req0 we0 addr0 wdata0 | req1 we1 addr1 wdata1 | expected: gnt0 gnt1 enb web addrb dib rv0 rv1 rdata
    vt[0]  = '{1'b1,1'b0,8'h20,16'h0, 1'b1,1'b0,8'h21,16'h0, 1'b1,1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,16'h0};
    vt[1]  = '{1'b1,1'b0,8'h20,16'h0, 1'b1,1'b0,8'h21,16'h0, 1'b0,1'b1,1'b1,1'b0,8'h20,16'h0, 1'b0,1'b0,16'h0};
    vt[2]  = '{1'b1,1'b0,8'h20,16'h0, 1'b1,1'b0,8'h21,16'h0, 1'b1,1'b0,1'b1,1'b0,8'h21,16'h0, 1'b1,1'b0,16'h2020};
    vt[3]  = '{1'b1,1'b0,8'h20,16'h0, 1'b1,1'b0,8'h21,16'h0, 1'b0,1'b1,1'b1,1'b0,8'h20,16'h0, 1'b0,1'b1,16'h2121};
    vt[4]  = '{1'b1,1'b0,8'h20,16'h0, 1'b1,1'b0,8'h21,16'h0, 1'b1,1'b0,1'b1,1'b0,8'h21,16'h0, 1'b1,1'b0,16'h2020};
    vt[5]  = '{1'b1,1'b0,8'h20,16'h0, 1'b1,1'b0,8'h21,16'h0, 1'b0,1'b1,1'b1,1'b0,8'h20,16'h0, 1'b0,1'b1,16'h2121};
    vt[6]  = '{1'b1,1'b0,8'h05,16'h0, 1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b1,1'b0,8'h21,16'h0, 1'b1,1'b0,16'h2020};
    vt[7]  = '{1'b0,1'b0,8'h00,16'h0, 1'b1,1'b1,8'h10,16'h1234, 1'b0,1'b1,1'b1,1'b0,8'h05,16'h0, 1'b0,1'b1,16'h2121};
    vt[8]  = '{1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,8'h10,16'h0, 1'b0,1'b1,1'b1,1'b1,8'h10,16'h1234, 1'b1,1'b0,16'hA5A5};
    vt[9]  = '{1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b1,1'b0,8'h10,16'h0, 1'b0,1'b0,16'h0};
    vt[10] = '{1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b0,8'h10,16'h0, 1'b0,1'b1,16'h1234};
    vt[11] = '{1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b0,8'h10,16'h0, 1'b0,1'b0,16'h0};

    // Reset state
    idle_in();
    repeat (2) @(negedge CLK);
    chk("rst ENB", 32'(ENB), 32'(1'b0));
    chk("rst WEB", 32'(WEB), 32'(1'b0));
    chk("rst ADDRB", 32'(ADDRB), 32'(8'h00));
    chk("rst DIB", 32'(DIB), 32'(16'h0000));
    chk("rst RVALID0", 32'(RVALID0), 32'(1'b0));
    chk("rst RVALID1", 32'(RVALID1), 32'(1'b0));
    chk("rst BUSY", 32'(BUSY), 32'(1'b0));
    chk("rst BUSY clear-on-reset", 32'(c_busy), 32'(1'b1));
    RST = 1'b0;

    // Vector table: contention alternation, single requests, write then read-back
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      REQ0 = vt[i].req0; WE0 = vt[i].we0; ADDR0 = vt[i].addr0; WDATA0 = vt[i].wdata0;
      REQ1 = vt[i].req1; WE1 = vt[i].we1; ADDR1 = vt[i].addr1; WDATA1 = vt[i].wdata1;
      #1;
      chk($sformatf("v%0d GNT0", i), 32'(GNT0), 32'(vt[i].gnt0));
      chk($sformatf("v%0d GNT1", i), 32'(GNT1), 32'(vt[i].gnt1));
      chk_bus($sformatf("v%0d", i), vt[i].enb, vt[i].web, vt[i].addrb);
      if (vt[i].enb && vt[i].web) chk($sformatf("v%0d DIB", i), 32'(DIB), 32'(vt[i].dib));
      chk($sformatf("v%0d RVALID0", i), 32'(RVALID0), 32'(vt[i].rv0));
      chk($sformatf("v%0d RVALID1", i), 32'(RVALID1), 32'(vt[i].rv1));
      if (vt[i].rv0 || vt[i].rv1) chk($sformatf("v%0d RDATA", i), 32'(RDATA), 32'(vt[i].rdata));
    end

    // Read one cycle before the fill, then fill with REQ0 held high
    @(negedge CLK); idle_in(); REQ0 = 1'b1; ADDR0 = 8'h20; #1;
    chk("pre-fill GNT0", 32'(GNT0), 32'(1'b1));
    @(negedge CLK); ADDR0 = 8'h10; CLR_START = 1'b1; #1;
    chk("clr-start GNT0", 32'(GNT0), 32'(1'b0));
    chk("clr-start BUSY", 32'(BUSY), 32'(1'b0));
    chk_bus("clr-start", 1'b1, 1'b0, 8'h20);
    @(negedge CLK); CLR_START = 1'b0; #1;
    chk("fill-first GNT0", 32'(GNT0), 32'(1'b0));
    chk("fill-first BUSY", 32'(BUSY), 32'(1'b1));
    chk("fill-first ENB", 32'(ENB), 32'(1'b0));
    chk("in-flight RVALID0", 32'(RVALID0), 32'(1'b1));
    chk("in-flight RDATA", 32'(RDATA), 32'(16'h2020));
    for (int k = 0; k < 256; k++) begin
      @(negedge CLK); CLR_START = (k == 100); #1;
      chk_bus($sformatf("fill%0d", k), 1'b1, 1'b1, 8'(k));
      chk($sformatf("fill%0d DIB", k), 32'(DIB), 32'(16'h0000));
      chk($sformatf("fill%0d BUSY", k), 32'(BUSY), 32'(k != 255));
      chk($sformatf("fill%0d GNT0", k), 32'(GNT0), 32'(k == 255));
    end
    @(negedge CLK); idle_in(); #1;
    chk_bus("post-fill read", 1'b1, 1'b0, 8'h10);
    chk("post-fill BUSY", 32'(BUSY), 32'(1'b0));
    @(negedge CLK); #1;
    chk("post-fill RVALID0", 32'(RVALID0), 32'(1'b1));
    chk("post-fill RDATA", 32'(RDATA), 32'(16'h0000));

    // Reset at fill count 0x40
    @(negedge CLK); CLR_START = 1'b1;
    @(negedge CLK); CLR_START = 1'b0;
    begin
      int n = 0;
      while (!(ENB && WEB && ADDRB == 8'h40) && n < 300) begin
        @(negedge CLK); #1;
        n++;
      end
      chk("reach fill 0x40", 32'(n < 300), 32'(1'b1));
    end
    #2; RST = 1'b1; #1;
    chk("abort BUSY", 32'(BUSY), 32'(1'b0));
    chk("abort ENB", 32'(ENB), 32'(1'b0));
    chk("abort RVALID0", 32'(RVALID0), 32'(1'b0));
    chk("abort RVALID1", 32'(RVALID1), 32'(1'b0));
    chk("abort BUSY clear-on-reset", 32'(c_busy), 32'(1'b1));
    @(negedge CLK); RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      chk($sformatf("restart%0d ENB", k), 32'(c_enb & c_web), 32'(1'b1));
      chk($sformatf("restart%0d ADDRB", k), 32'(c_addrb), 32'(8'(k)));
      chk($sformatf("restart%0d BUSY", k), 32'(BUSY), 32'(1'b0));
    end

    // Reset with a read in flight: its RVALID must never appear
    @(negedge CLK); idle_in(); REQ0 = 1'b1; ADDR0 = 8'h05; #1;
    chk("flight GNT0", 32'(GNT0), 32'(1'b1));
    @(negedge CLK); idle_in(); #1;
    chk_bus("flight", 1'b1, 1'b0, 8'h05);
    #2; RST = 1'b1; #1;
    chk("flight-rst ENB", 32'(ENB), 32'(1'b0));
    @(negedge CLK); RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      chk($sformatf("flight-drop%0d RVALID0", k), 32'(RVALID0), 32'(1'b0));
      chk($sformatf("flight-drop%0d RVALID1", k), 32'(RVALID1), 32'(1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
